// File: rtl/shift_add_mult18.sv
// Sequential 18x18 unsigned shift-and-add multiplier with a level-sensitive calc_start handshake.
// Define SHIFT_ADD_MULT18_RADIX4_EN to retire two multiplier bits per cycle (9 iterations instead of 18).
module shift_add_mult18 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        calc_start,
  input  logic [17:0] dataa,
  input  logic [17:0] datab,
  output logic [35:0] result,
  output logic        done,
  output logic        busy
);

`ifdef SHIFT_ADD_MULT18_RADIX4_EN
  localparam int         SHIFT     = 2;
  localparam logic [4:0] LAST_STEP = 5'd8;
`else
  localparam int         SHIFT     = 1;
  localparam logic [4:0] LAST_STEP = 5'd17;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, next_state;
  logic [35:0] mcand, acc, addend, sum;
  logic [17:0] mplier;
  logic [4:0]  step;
  logic        done_d, busy_d;
`ifdef SHIFT_ADD_MULT18_RADIX4_EN
  logic [35:0] mcand3;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  // Dropping calc_start is an abort in BUSY and an acknowledge in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (calc_start) next_state = BUSY;
      BUSY: begin
        if (!calc_start)             next_state = IDLE;
        else if (step == LAST_STEP)  next_state = DONE;
      end
      DONE: if (!calc_start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    done_d = (next_state == DONE);
    busy_d = (next_state == BUSY);
  end

  // The multiplicand register is pre-shifted each step, so it already carries the bit weight.
  always_comb begin
`ifdef SHIFT_ADD_MULT18_RADIX4_EN
    case (mplier[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = mcand;
      2'd2:    addend = mcand << 1;
      default: addend = mcand3;
    endcase
`else
    addend = mplier[0] ? mcand : '0;
`endif
    sum = acc + addend;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
      result <= '0;
`ifdef SHIFT_ADD_MULT18_RADIX4_EN
      mcand3 <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (calc_start) begin
            mcand  <= {18'b0, dataa};
            mplier <= datab;
            acc    <= '0;
            step   <= '0;
`ifdef SHIFT_ADD_MULT18_RADIX4_EN
            mcand3 <= {18'b0, dataa} + {17'b0, dataa, 1'b0};
`endif
          end
        end
        BUSY: begin
          if (!calc_start) begin
            acc  <= '0;
            step <= '0;
          end else begin
            acc    <= sum;
            mcand  <= mcand << SHIFT;
            mplier <= mplier >> SHIFT;
            step   <= step + 5'd1;
`ifdef SHIFT_ADD_MULT18_RADIX4_EN
            mcand3 <= mcand3 << SHIFT;
`endif
            if (step == LAST_STEP) result <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult18.sv
// Self-checking bench for shift_add_mult18: directed corner cases plus random operands vs. an arithmetic model.
// Build with SHIFT_ADD_MULT18_RADIX4_EN defined to check the radix-4 latency.
module tb_shift_add_mult18;

`ifdef SHIFT_ADD_MULT18_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 18;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        calc_start = 1'b0;
  logic [17:0] dataa = '0;
  logic [17:0] datab = '0;
  logic [35:0] result;
  logic        done;
  logic        busy;

  int          testCount = 0;
  int          failCount = 0;
  logic [35:0] lastResult = '0;

  shift_add_mult18 dut (
    .CLK(CLK), .RST(RST), .calc_start(calc_start),
    .dataa(dataa), .datab(datab),
    .result(result), .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [35:0] got, input logic [35:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [17:0] a, input logic [17:0] b);
    @(negedge CLK);
    calc_start = start;
    dataa      = a;
    datab      = b;
  endtask

  function automatic logic [35:0] model(input logic [17:0] a, input logic [17:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[35:0];
  endfunction

  // Start an operation, scramble operands while it runs, and check latency and product.
  task automatic runOp(input logic [17:0] a, input logic [17:0] b, input string tag);
    int cycles;
    logic [35:0] exp;
    exp = model(a, b);
    applyStimulus(1'b1, a, b);
    @(posedge CLK); #1;
    checkOutput({tag, "_busy_after_start"}, {35'b0, busy}, 36'd1);
    cycles = 0;
    while (!done && cycles < 100) begin
      dataa = 18'($urandom);
      datab = 18'($urandom);
      @(posedge CLK); #1;
      cycles++;
      if (cycles == 1)
        checkOutput({tag, "_result_hidden"}, result, lastResult);
    end
    checkOutput({tag, "_latency"}, 36'(cycles), 36'(LAT));
    checkOutput({tag, "_product"}, result, exp);
    checkOutput({tag, "_busy_at_done"}, {35'b0, busy}, 36'd0);
    lastResult = exp;
  endtask

  task automatic releaseOp(input string tag);
    applyStimulus(1'b0, 18'($urandom), 18'($urandom));
    @(posedge CLK); #1;
    checkOutput({tag, "_done_cleared"}, {35'b0, done}, 36'd0);
    checkOutput({tag, "_result_kept"}, result, lastResult);
  endtask

  initial begin
    logic [17:0] ra, rb;

    #2;
    checkOutput("reset_result", result, 36'd0);
    checkOutput("reset_done", {35'b0, done}, 36'd0);
    checkOutput("reset_busy", {35'b0, busy}, 36'd0);
    @(negedge CLK); RST = 1'b1;

    runOp(18'd3, 18'd5, "small");
    checkOutput("small_literal", result, 36'h0_0000_000F);
    releaseOp("small");
    runOp(18'h3FFFF, 18'h3FFFF, "max");
    checkOutput("max_literal", result, 36'hF_FFF8_0001);
    releaseOp("max");
    runOp(18'h20000, 18'd2, "msb");
    checkOutput("msb_literal", result, 36'h0_0004_0000);
    releaseOp("msb");
    runOp(18'd0, 18'($urandom), "zero");
    releaseOp("zero");

    // Abort: calc_start is low at E10.
    applyStimulus(1'b1, 18'd1234, 18'd4321);
    @(posedge CLK);
    repeat (9) @(posedge CLK);
    applyStimulus(1'b0, 18'd0, 18'd0);
    @(posedge CLK); #1;
    checkOutput("abort_busy", {35'b0, busy}, 36'd0);
    checkOutput("abort_done", {35'b0, done}, 36'd0);
    checkOutput("abort_result", result, lastResult);
    repeat (5) begin
      @(posedge CLK); #1;
      checkOutput("abort_done_quiet", {35'b0, done}, 36'd0);
    end
    runOp(18'd1234, 18'd4321, "after_abort");
    releaseOp("after_abort");

    // Asynchronous reset mid-operation, between clock edges.
    applyStimulus(1'b1, 18'd100, 18'd200);
    @(posedge CLK);
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("rst_mid_done", {35'b0, done}, 36'd0);
    checkOutput("rst_mid_busy", {35'b0, busy}, 36'd0);
    checkOutput("rst_mid_result", result, 36'd0);
    lastResult = '0;
    calc_start = 1'b0;
    @(negedge CLK); RST = 1'b1;
    runOp(18'd7, 18'd9, "post_reset");
    checkOutput("post_reset_literal", result, 36'd63);
    releaseOp("post_reset");

    // Holding calc_start high after completion must not restart.
    runOp(18'd555, 18'd777, "hold");
    repeat (30) begin
      @(posedge CLK); #1;
      checkOutput("hold_done", {35'b0, done}, 36'd1);
    end
    checkOutput("hold_busy", {35'b0, busy}, 36'd0);
    checkOutput("hold_result", result, lastResult);
    releaseOp("hold");
    runOp(18'd999, 18'd888, "hold_next");
    releaseOp("hold_next");

    for (int i = 0; i < 20; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      runOp(ra, rb, "rand");
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      releaseOp("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/shift_add_mult18.md
SHIFT_ADD_MULT18 -- requirements
Module: shift_add_mult18

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port calc_start, input, 1 bit: level request from the initiator; high requests an operation, low returns the block to idle.
REQ-004 SHALL have port dataa, input, 18 bits: unsigned multiplicand.
REQ-005 SHALL have port datab, input, 18 bits: unsigned multiplier.
REQ-006 SHALL have port result, output, 36 bits: registered unsigned product dataa*datab.
REQ-007 SHALL have port done, output, 1 bit: registered; high while result holds the product of the current request.
REQ-008 SHALL have port busy, output, 1 bit: registered; high while iterating.

Function
REQ-009 SHALL implement three states, IDLE, BUSY and DONE, with done=1 only in DONE and busy=1 only in BUSY.
REQ-010 SHALL, in IDLE on an edge with calc_start=1, latch dataa/datab into internal operand registers, clear the accumulator and step counter, and enter BUSY (start edge E0).
REQ-011 SHALL ignore changes on dataa/datab after E0 until the next start.
REQ-012 SHALL, in BUSY, consume the multiplier LSB-first, one bit per cycle: add the multiplicand shifted by the bit index to the 36-bit accumulator if the bit is 1, then increment the counter.
REQ-013 SHALL finish after 18 BUSY edges (E1..E18): at E18 write the final accumulator to result, enter DONE, done=1, busy=0 (latency 18 cycles after E0).
REQ-014 SHALL perform all arithmetic unsigned at full 36-bit width with no truncation or overflow; the product of the maxima SHALL fit exactly.
REQ-015 SHALL remain in DONE with result and done stable while calc_start=1; holding calc_start high SHALL NOT start a new operation.
REQ-016 SHALL, in DONE on an edge with calc_start=0, enter IDLE with done=0 while result retains its value.
REQ-017 SHALL, in BUSY on an edge with calc_start=0, abort: enter IDLE with done=0 and busy=0, result unchanged, and discard the partial accumulator.
REQ-018 SHALL require calc_start low on at least one edge between operations; a new operation starts only from IDLE.
REQ-019 SHALL write result only at completion; the intermediate accumulator SHALL NOT be visible on result.

Reset
REQ-020 SHALL, while RST=0, asynchronously force state=IDLE, done=0, busy=0, result=0, and clear the accumulator, counter and operand registers.
REQ-021 SHALL abort any operation in progress when RST is asserted mid-operation; after release it SHALL behave as from IDLE, starting on the first edge where calc_start=1.

Configuration
REQ-022 SHALL support the macro SHIFT_ADD_MULT18_RADIX4_EN.
REQ-023 SHALL, with SHIFT_ADD_MULT18_RADIX4_EN defined, consume 2 multiplier bits per BUSY cycle, adding 0, 1x, 2x or 3x the shifted multiplicand (3x precomputed at E0): 9 BUSY edges, done at E9.
REQ-024 SHALL, without the macro, use the radix-2 behaviour of REQ-012/REQ-013 (done at E18); results SHALL be identical in both builds.

Verification
REQ-025 SHALL cover: dataa=3, datab=5, calc_start high -> busy for 18 cycles, then done=1, result=36'h0_0000_000F (9 cycles in RADIX4 build).
REQ-026 SHALL cover: dataa=datab=18'h3FFFF -> result=36'hF_FFF8_0001; dataa=18'h20000, datab=2 -> result=36'h0_0004_0000; dataa=0 -> result=0.
REQ-027 SHALL cover: change dataa/datab every cycle after E0 -> result equals the product of the E0 operands.
REQ-028 SHALL cover: drop calc_start at E10 -> IDLE, done never rises, result keeps its previous value; re-raise -> a full new operation.
REQ-029 SHALL cover: assert RST at E5 without a clock edge -> done=0, busy=0, result=0 immediately; after release, 7*9 -> result=63 after full latency.
REQ-030 SHALL cover: hold calc_start high 30 cycles after done -> done stays 1, no restart; lower for 1 cycle, then raise with new operands -> new product after full latency.
